// File: rtl/pc_pkg.sv
// Shared types for the PC / return-stack slice: the per-cycle operation
// and its fixed priority decode.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_LOAD,
        PC_CALL,
        PC_RETURN,
        PC_OFFSET,
        PC_INC
    } pc_op_t;

    // Stall > Load > Call > Return > Offset > increment; lower requests are dropped.
    function automatic pc_op_t decode_op(
        input logic stall,
        input logic load,
        input logic call,
        input logic ret,
        input logic offset
    );
        pc_op_t op;
        if (stall)       op = PC_HOLD;
        else if (load)   op = PC_LOAD;
        else if (call)   op = PC_CALL;
        else if (ret)    op = PC_RETURN;
        else if (offset) op = PC_OFFSET;
        else             op = PC_INC;
        return op;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Register-array LIFO holding return addresses. A write pointer walks a ring,
// so a push when full overwrites the oldest entry while the count saturates.
module return_stack #(
    parameter int Depth    = 4,
    parameter int Width    = 16,
    parameter int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [Width-1:0]    push_data,
    output logic [Width-1:0]    top_data,
    output logic [CntWidth-1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] DepthCount = CntWidth'(Depth);
    localparam logic [IdxWidth-1:0] LastIdx    = IdxWidth'(Depth - 1);

    logic [Width-1:0]    mem [Depth];
    logic [IdxWidth-1:0] wptr;
    logic [IdxWidth-1:0] wptr_inc;
    logic [IdxWidth-1:0] top_idx;

    assign wptr_inc = (wptr == LastIdx) ? '0 : wptr + IdxWidth'(1);
    assign top_idx  = (wptr == '0) ? LastIdx : wptr - IdxWidth'(1);

    assign top_data = mem[top_idx];
    assign full     = (count == DepthCount);
    assign empty    = (count == '0);

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            count <= '0;
        end else if (push) begin
            wptr <= wptr_inc;
            if (!full) begin
                count <= count + CntWidth'(1);
            end
        end else if (pop) begin
            wptr  <= top_idx;
            count <= count - CntWidth'(1);
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with integrated return-address stack and sticky error flags.
// Define PC_STACK_WRAP_EN to make the stack circular (calls when full still push).
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int               Width       = 16,
    parameter int               OffsetWidth = 9,
    parameter int               StackDepth  = 4,
    parameter logic [Width-1:0] ResetValue  = '0
) (
    input  logic                             Clock,
    input  logic                             nReset,
    input  logic                             Stall,
    input  logic                             LoadEnable,
    input  logic [Width-1:0]                 LoadValue,
    input  logic                             OffsetEnable,
    input  logic [OffsetWidth-1:0]           Offset,
    input  logic                             CallEnable,
    input  logic                             ReturnEnable,
    input  logic                             ClearError,
    output logic [Width-1:0]                 CounterValue,
    output logic [$clog2(StackDepth+1)-1:0]  StackCount,
    output logic                             StackEmpty,
    output logic                             StackFull,
    output logic                             StackOverflow,
    output logic                             StackUnderflow
);

    pc_op_t           op;
    logic [Width-1:0] pc_q;
    logic [Width-1:0] pc_next;
    logic [Width-1:0] pc_inc;
    logic [Width-1:0] offset_ext;
    logic [Width-1:0] top_data;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             overflow_set;
    logic             underflow_set;

    assign op         = decode_op(Stall, LoadEnable, CallEnable, ReturnEnable, OffsetEnable);
    assign pc_inc     = pc_q + Width'(1);
    assign offset_ext = Width'($signed(Offset));

`ifdef PC_STACK_WRAP_EN
    assign push = (op == PC_CALL);
`else
    assign push = (op == PC_CALL) && !full;
`endif
    assign pop           = (op == PC_RETURN) && !empty;
    assign overflow_set  = (op == PC_CALL) && full;
    assign underflow_set = (op == PC_RETURN) && empty;

    // A call that cannot push degrades to a plain increment; a failed return holds.
    always_comb begin
        pc_next = pc_q;
        case (op)
            PC_LOAD:   pc_next = LoadValue;
            PC_CALL:   pc_next = push ? LoadValue : pc_inc;
            PC_RETURN: pc_next = pop ? top_data : pc_q;
            PC_OFFSET: pc_next = pc_q + offset_ext;
            PC_INC:    pc_next = pc_inc;
            default:   pc_next = pc_q;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc_q <= ResetValue;
        end else begin
            pc_q <= pc_next;
        end
    end

    // A fresh error in the same cycle as ClearError leaves the flag set.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            StackOverflow  <= 1'b0;
            StackUnderflow <= 1'b0;
        end else begin
            StackOverflow  <= overflow_set  | (StackOverflow  & ~ClearError);
            StackUnderflow <= underflow_set | (StackUnderflow & ~ClearError);
        end
    end

    return_stack #(
        .Depth (StackDepth),
        .Width (Width)
    ) u_stack (
        .clk       (Clock),
        .rst_n     (nReset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (top_data),
        .count     (StackCount),
        .full      (full),
        .empty     (empty)
    );

    assign CounterValue = pc_q;
    assign StackEmpty   = empty;
    assign StackFull    = full;

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
Parametrised program counter with an integrated return-address stack (LIFO) for subroutine call and return. It supersedes the fixed 16-bit counter in the CPU fetch path. It adds free-running increment, stall, call/return, stack status and sticky error flags. It sits between the control unit, which drives the request strobes, and instruction memory, which consumes CounterValue as the fetch address.

Parameters:
Width, 16, counter/address width in bits
OffsetWidth, 9, width of signed relative-branch offset (<= Width)
StackDepth, 4, return-stack entries (>= 1)
ResetValue, 0, CounterValue after reset

Ports:
Clock  in  1  system clock, all state updates on rising edge
nReset  in  1  asynchronous active-low reset
Stall  in  1  hold PC; all requests ignored this cycle
LoadEnable  in  1  absolute jump to LoadValue
LoadValue  in  Width  jump/call target
OffsetEnable  in  1  relative branch by Offset
Offset  in  OffsetWidth  signed two's-complement offset
CallEnable  in  1  push CounterValue+1, jump to LoadValue
ReturnEnable  in  1  pop top of stack into PC
ClearError  in  1  clear sticky error flags
CounterValue  out  Width  current PC (registered)
StackCount  out  $clog2(StackDepth+1)  entries in use
StackEmpty  out  1  StackCount == 0
StackFull  out  1  StackCount == StackDepth
StackOverflow  out  1  sticky: call attempted when full
StackUnderflow  out  1  sticky: return attempted when empty

Behaviour:
- nReset low (asynchronous, any time including mid-call): CounterValue=ResetValue, StackCount=0, StackEmpty=1, StackFull=0, both error flags 0. Stack contents are don't-care.
- All outputs are registered. A request sampled at edge N is visible after edge N. Latency is 1 cycle.
- Per-cycle priority: Stall > LoadEnable > CallEnable > ReturnEnable > OffsetEnable > increment.
- Stall: PC and stack hold. ClearError still acts.
- Load: PC=LoadValue. Stack unchanged.
- Call, stack not full: stack[top]=CounterValue+1 (mod 2^Width), StackCount+1, PC=LoadValue.
- Call, stack full: no push, PC increments, StackOverflow set.
- Return, stack not empty: PC=stack[top], StackCount-1.
- Return, stack empty: PC holds, StackUnderflow set.
- Offset: PC = CounterValue + sign-extend(Offset), mod 2^Width.
- Default: PC = CounterValue+1, mod 2^Width (0xFFFF -> 0x0000 at Width=16).
- Simultaneous requests: only the highest-priority request acts; the rest are dropped with no side effects. Call+Return in the same cycle is therefore a call.
- ClearError: both flags cleared. A new error in the same cycle wins (flag reads 1).
- Flags never self-clear; only ClearError or reset clears them.

Optional Feature:
PC_STACK_WRAP_EN
- Defined: the stack is circular. A call when full still pushes (overwrites oldest entry) and jumps. StackCount saturates at StackDepth, and StackOverflow is still set. StackDepth must be a power of two.
- Undefined: full-stack behaviour is as in Behaviour (call degrades to increment).

Decomposition:
- Package pc_pkg: enum pc_op_t {PC_HOLD, PC_LOAD, PC_CALL, PC_RETURN, PC_OFFSET, PC_INC} and a priority-decode function returning pc_op_t.
- Sub-module return_stack: register-array LIFO with push/pop/count/full/empty and optional wrap. The top level holds the PC register, op decode, next-PC mux and error flags.

Test Plan:
- Reset/increment: nReset low then high, idle 3 cycles -> CounterValue 0,1,2,3. Assert nReset mid-count at PC=0x0007 -> immediately 0x0000, StackCount 0.
- Load/offset: LoadValue=0x0008+LoadEnable -> 0x0008. At PC=0x0010, Offset=9'h1FF -> 0x000F. At 0xFFFE, Offset=+5 -> 0x0003. Idle at 0xFFFF -> 0x0000.
- Call/return: at PC=0x0020, CallEnable with LoadValue=0x0100 -> PC 0x0100, StackCount 1. Nested call at 0x0105 to 0x0200 -> StackCount 2. Return -> 0x0106. Return -> 0x0021, StackEmpty 1.
- Overflow (macro off): 4 calls fill the stack (StackFull 1). 5th call at PC=0x0300 -> PC 0x0301, StackOverflow 1, StackCount 4. ClearError -> flag 0.
- Underflow/priority: ReturnEnable on empty stack at PC=0x0040 -> PC 0x0040, StackUnderflow 1. Load+Call+Return together with LoadValue=0x0500 -> PC 0x0500, StackCount unchanged. Stall with CallEnable -> PC and stack unchanged.
- Wrap (PC_STACK_WRAP_EN): 5 calls with return addresses A1..A5 -> StackCount 4, StackOverflow 1. Four returns yield A5, A4, A3, A2.
